// File: rtl/cl_axi_rd_arb_if.sv
// cl_axi_rd_arb_if: AXI4 read address/data channel bundle with master/slave views
interface cl_axi_rd_arb_if #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  modport master (
    output arid, araddr, arlen, arsize, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cl_axi_rd_arb.sv
// cl_axi_rd_arb: two-requester AXI4 read arbiter, round-robin AR with outstanding-burst limit and ID-routed R
module cl_axi_rd_arb #(
  parameter int ID_W      = 16,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                 clk,
  input  logic                 sync_rst,
  cl_axi_rd_arb_if.slave       s0,
  cl_axi_rd_arb_if.slave       s1,
  cl_axi_rd_arb_if.master      m,
  output logic [CNT_W-1:0]     outst0,
  output logic [CNT_W-1:0]     outst1,
  output logic                 busy,
  output logic                 err_unexp
);
  logic              r_arvalid;
  logic [ID_W:0]     r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic              r_rr;
  logic [CNT_W-1:0]  r_outst0;
  logic [CNT_W-1:0]  r_outst1;
  logic              r_err;
  logic              w_free;
  logic              w_el0;
  logic              w_el1;
  logic              w_g0;
  logic              w_g1;
  logic              w_src;
  logic              w_rlast_hs;
  logic              w_d0;
  logic              w_d1;
  logic [DATA_W-1:0] w_rdata;
  always_comb begin
    w_free = !r_arvalid || m.arready;
    w_el0  = s0.arvalid && (r_outst0 < CNT_W'(MAX_OUTST));
    w_el1  = s1.arvalid && (r_outst1 < CNT_W'(MAX_OUTST));
    // r_rr=0 favours requester 0 when both are eligible
    w_g0   = !sync_rst && w_free && w_el0 && (!w_el1 || !r_rr);
    w_g1   = !sync_rst && w_free && w_el1 && (!w_el0 || r_rr);
  end
  assign s0.arready = w_g0;
  assign s1.arready = w_g1;
  assign m.arvalid  = r_arvalid;
  assign m.arid     = r_arid;
  assign m.araddr   = r_araddr;
  assign m.arlen    = r_arlen;
  assign m.arsize   = r_arsize;
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_rr      <= 1'b0;
    end else if (w_g0 || w_g1) begin
      r_arvalid <= 1'b1;
      r_arid    <= w_g1 ? {1'b1, s1.arid} : {1'b0, s0.arid};
      r_araddr  <= w_g1 ? s1.araddr : s0.araddr;
      r_arlen   <= w_g1 ? s1.arlen : s0.arlen;
      r_arsize  <= w_g1 ? s1.arsize : s0.arsize;
      r_rr      <= w_g0;
    end else if (w_free) begin
      r_arvalid <= 1'b0;
    end
  end
  assign w_src   = m.rid[ID_W];
  assign w_rdata = m.rdata;
  assign s0.rvalid = m.rvalid && !w_src;
  assign s1.rvalid = m.rvalid && w_src;
  assign s0.rid    = m.rid[ID_W-1:0];
  assign s1.rid    = m.rid[ID_W-1:0];
  assign s0.rdata  = w_rdata;
  assign s1.rdata  = w_rdata;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign m.rready  = !sync_rst && (w_src ? s1.rready : s0.rready);
  assign w_rlast_hs = m.rvalid && m.rready && m.rlast;
  assign w_d0       = w_rlast_hs && !w_src;
  assign w_d1       = w_rlast_hs && w_src;
  // A last beat for a source with nothing in flight is forwarded but only flagged
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_outst0 <= '0;
      r_outst1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_outst0 <= (w_g0 && !w_d0) ? r_outst0 + 1'b1 :
                  (!w_g0 && w_d0 && r_outst0 != '0) ? r_outst0 - 1'b1 : r_outst0;
      r_outst1 <= (w_g1 && !w_d1) ? r_outst1 + 1'b1 :
                  (!w_g1 && w_d1 && r_outst1 != '0) ? r_outst1 - 1'b1 : r_outst1;
      r_err    <= r_err || (w_d0 && r_outst0 == '0) || (w_d1 && r_outst1 == '0);
    end
  end
  assign outst0    = r_outst0;
  assign outst1    = r_outst1;
  assign err_unexp = r_err;
  assign busy      = r_arvalid || r_outst0 != '0 || r_outst1 != '0;
endmodule
